// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared loader definitions: FSM states and load-stream byte counts
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_WRITE,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam int LEN_BYTES  = 2;
    localparam int WORD_BYTES = 4;
    localparam int CSUM_BYTES = 1;

    localparam logic [1:0] LAST_BYTE_IDX = 2'(WORD_BYTES - 1);

endpackage

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - MSB-first byte-to-word shift register with byte counter
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  in_byte,
    output logic [31:0] word,
    output logic        last_byte
);

    logic [31:0] word_q, word_d;
    logic [1:0]  cnt_q, cnt_d;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clear) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (shift_en) begin
            word_d = {word_q[23:0], in_byte};
            cnt_d  = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word      = word_q;
    assign last_byte = shift_en && (cnt_q == LAST_BYTE_IDX);

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - serial instruction-memory loader with length header and XOR checksum
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        error
);

    state_t      state_q, state_d;
    logic [7:0]  len_hi_q, len_hi_d;
    logic [15:0] len_q, len_d;
    logic [15:0] word_index_q, word_index_d;
    logic [7:0]  csum_q, csum_d;

    logic        idle_like;
    logic        start_ok;
    logic        accept;
    logic        last_byte;
    logic [15:0] n_rx;
    logic [31:0] packed_word;

    assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR);
    assign start_ok  = start && idle_like;
    assign in_ready  = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                       (state_q == ST_DATA)   || (state_q == ST_CSUM);
    assign accept    = in_valid && in_ready;
    assign n_rx      = {len_hi_q, in_byte};

    byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_ok),
        .shift_en  (accept && (state_q == ST_DATA)),
        .in_byte   (in_byte),
        .word      (packed_word),
        .last_byte (last_byte)
    );

    always_comb begin
        state_d      = state_q;
        len_hi_d     = len_hi_q;
        len_d        = len_q;
        word_index_d = word_index_q;
        csum_d       = csum_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d      = ST_LEN_HI;
                    word_index_d = '0;
                    csum_d       = '0;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    len_hi_d = in_byte;
                    csum_d   = csum_q ^ in_byte;
                    state_d  = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    len_d  = n_rx;
                    csum_d = csum_q ^ in_byte;
                    if ({16'd0, n_rx} > 32'(DEPTH_WORDS)) begin
                        state_d = ST_ERR;
                    end else if (n_rx == 16'd0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    csum_d = csum_q ^ in_byte;
                    if (last_byte) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                // The strobe uses the current index; the bump is seen from the next word on.
                word_index_d = word_index_q + 16'd1;
                state_d      = (word_index_q + 16'd1 == len_q) ? ST_CSUM : ST_DATA;
            end
            ST_CSUM: begin
                if (accept) begin
                    state_d = (in_byte == csum_q) ? ST_DONE : ST_ERR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            len_hi_q     <= '0;
            len_q        <= '0;
            word_index_q <= '0;
            csum_q       <= '0;
        end else begin
            state_q      <= state_d;
            len_hi_q     <= len_hi_d;
            len_q        <= len_d;
            word_index_q <= word_index_d;
            csum_q       <= csum_d;
        end
    end

    assign imem_we    = (state_q == ST_WRITE);
    assign imem_addr  = {14'd0, word_index_q, 2'b00};
    assign imem_wdata = packed_word;
    assign busy       = !idle_like;
    assign done       = (state_q == ST_DONE);
    assign error      = (state_q == ST_ERR);
    assign cpu_reset  = (state_q != ST_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized scoreboard bench for imem_loader
module tb_imem_loader;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset, start, in_valid;
    logic [7:0]  in_byte;
    logic        in_ready, imem_we, cpu_reset, busy, done, error;
    logic [31:0] imem_addr, imem_wdata;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [7:0] stream[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic       exp_done, exp_err, exp_ovf;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH_WORDS(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (imem_we !== 1'b0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: we=%b addr %h data %h, expected no write",
                         imem_we, imem_addr, imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("write_addr", imem_addr, mon_e.addr);
                chk("write_data", imem_wdata, mon_e.data);
            end
        end
    end

    // Reference: header gives N; each 4 bytes is one big-endian word at byte address 4*i;
    // trailing byte must equal the XOR of everything before it.
    task automatic model_load();
        int         n;
        logic [7:0] cs;
        n  = {stream[0], stream[1]};
        cs = 8'h00;
        exp_ovf = (n > DEPTH);
        if (exp_ovf) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
            return;
        end
        for (int i = 0; i < stream.size() - 1; i++) cs = cs ^ stream[i];
        for (int w = 0; w < n; w++) begin
            exp_q.push_back('{addr: 32'(w * 4),
                              data: {stream[2+4*w], stream[3+4*w], stream[4+4*w], stream[5+4*w]}});
        end
        exp_done = (stream[stream.size()-1] == cs);
        exp_err  = !exp_done;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input logic with_start);
        int waited;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_byte  = b;
        in_valid = 1'b1;
        start    = with_start;
        waited   = 0;
        while (!in_ready && waited < 40) begin
            @(negedge clk);
            start = 1'b0;
            waited++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL in_ready_timeout: got 0 expected 1 within 40 cycles");
        end else begin
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic run_load(input int max_gap, input int start_idx);
        int nsend;
        model_load();
        pulse_start();
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("cpu_reset_in_load", {31'd0, cpu_reset}, 32'd1);
        nsend = exp_ovf ? 2 : stream.size();
        for (int i = 0; i < nsend; i++) begin
            send_byte(stream[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0, i == start_idx);
        end
        @(negedge clk);
        chk("done", {31'd0, done}, {31'd0, exp_done});
        chk("error", {31'd0, error}, {31'd0, exp_err});
        chk("cpu_reset_end", {31'd0, cpu_reset}, {31'd0, !exp_done});
        chk("busy_end", {31'd0, busy}, 32'd0);
        chk("in_ready_end", {31'd0, in_ready}, 32'd0);
        chk("pending_writes", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    task automatic make_random(input int n, input logic bad);
        logic [7:0] cs, b;
        stream.delete();
        stream.push_back(8'(n >> 8));
        stream.push_back(8'(n));
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            stream.push_back(b);
        end
        cs = 8'h00;
        foreach (stream[i]) cs = cs ^ stream[i];
        if (bad) cs = cs ^ 8'($urandom_range(1, 255));
        stream.push_back(cs);
    endtask

    task automatic check_reset_values();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'd0);
        chk("rst_imem_wdata", imem_wdata, 32'd0);
        chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_values();
        reset = 1'b0;

        stream = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0C};
        run_load(0, -1);
        stream = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0D};
        run_load(0, -1);
        stream = {8'h00, 8'h00, 8'h00};
        run_load(0, -1);
        stream = {8'h01, 8'h01};
        run_load(0, -1);
        stream = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0C};
        run_load(3, -1);
        run_load(3, -1);

        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(stream[i], 0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values();
        @(negedge clk);
        reset = 1'b0;
        run_load(0, -1);

        run_load(1, 4);

        pulse_start();
        chk("cpu_reset_after_restart", {31'd0, cpu_reset}, 32'd1);
        chk("done_after_restart", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 10; k++) begin
            make_random(int'($urandom_range(0, 5)), ($urandom_range(0, 2) == 0));
            run_load(3, -1);
        end
        make_random(int'($urandom_range(257, 65535)), 1'b0);
        run_load(2, -1);
        make_random(DEPTH, 1'b0);
        run_load(0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, instruction-memory capacity in 32-bit words.
REQ-002 clk  input  1  single system clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
REQ-005 in_byte  input  8  serial load-stream byte.
REQ-006 in_valid  input  1  in_byte valid.
REQ-007 in_ready  output  1  loader accepts in_byte this cycle.
REQ-008 imem_we  output  1  instruction-memory write strobe, one-cycle pulse per word.
REQ-009 imem_addr  output  32  byte address of the word being written, word-aligned.
REQ-010 imem_wdata  output  32  assembled instruction word.
REQ-011 cpu_reset  output  1  holds the processor core in reset while high.
REQ-012 busy  output  1  load in progress.
REQ-013 done  output  1  last load completed with a good checksum.
REQ-014 error  output  1  last load aborted: length overflow or checksum mismatch.

Function
REQ-015 Stream format SHALL be: LEN_HI, LEN_LO (word count N, 16-bit, big-endian), then 4*N data bytes (each word MSB first), then one checksum byte.
REQ-016 A byte SHALL be accepted on posedge clk when in_valid and in_ready are both 1; no byte SHALL be consumed otherwise.
REQ-017 FSM states SHALL be IDLE, LEN_HI, LEN_LO, DATA, WRITE, CSUM, DONE, ERR.
REQ-018 Transitions: IDLE/DONE/ERR --start--> LEN_HI; LEN_HI --accept--> LEN_LO; LEN_LO --accept--> ERR if N>DEPTH_WORDS, CSUM if N=0, else DATA.
REQ-019 Further transitions: DATA --4th byte of word--> WRITE; WRITE --> DATA if words remain, else CSUM; CSUM --accept--> DONE if match, else ERR.
REQ-020 in_ready SHALL be 1 only in LEN_HI, LEN_LO, DATA and CSUM; it SHALL be 0 in WRITE.
REQ-021 In WRITE, imem_we SHALL be 1 for exactly that cycle, with imem_addr = word_index*4 and imem_wdata = the assembled word.
REQ-022 word_index SHALL start at 0 and increment once per WRITE; WRITE-to-WRITE latency SHALL be at least 5 cycles.
REQ-023 The checksum SHALL be the running 8-bit XOR of LEN_HI, LEN_LO and all data bytes; it SHALL be cleared on start.
REQ-024 busy SHALL be 1 in every state except IDLE, DONE and ERR.
REQ-025 cpu_reset SHALL be 1 in every state except DONE; it SHALL fall in the first cycle of DONE and rise in the cycle after a start is accepted.
REQ-026 done SHALL be 1 only in DONE, and error only in ERR; both SHALL hold until the next start or reset.
REQ-027 start while busy SHALL be ignored.
REQ-028 Words already written before an ERR SHALL remain written; no rollback.
REQ-029 Arbitrary in_valid gaps SHALL NOT change the written data, the written addresses or the final state.

Reset
REQ-030 On reset: state=IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, busy=0, done=0, error=0, word_index=0, checksum=0.
REQ-031 Reset mid-load SHALL abort immediately, produce no further write strobe, and leave the block ready for a fresh start.

Structure
REQ-032 State encodings and the stream-format byte counts SHALL be defined as constants in the shared MIPS definitions package.
REQ-033 Byte-to-word packing (MSB-first shift register plus 2-bit byte counter) SHALL be a sub-module named byte_packer.

Verification
REQ-034 Stream 00 02 20 08 00 05 20 09 00 0A 0C -> writes (0x0,20080005) then (0x4,2009000A), done=1, cpu_reset=0, error=0.
REQ-035 Same stream with checksum 0D -> both words written, error=1, done=0, cpu_reset stays 1.
REQ-036 Stream 00 00 00 -> no imem_we pulse, done=1; with DEPTH_WORDS=256, stream 01 01 -> ERR after LEN_LO, in_ready=0, no writes.
REQ-037 Stream from REQ-034 with random 0-3 cycle in_valid gaps -> identical writes and final state.
REQ-038 Reset asserted after 5 bytes accepted, then the full REQ-034 stream -> all outputs at reset values, then a correct load; no stray write during the reset.
REQ-039 start pulsed during DATA -> ignored, load completes normally; start pulsed in DONE -> cpu_reset=1 and done=0 the next cycle.
